voter_plus_ext: RTL and testbench

Parametrised session-based weighted voting counter; successor to the fixed 32/8/1-voter single-tally voter. Three voter classes (normal, VIP, VVIP) of configurable count and weight feed a saturating or wrapping tally. Each voter counts at most once per session; an open/close session FSM reports a pass/fail verdict against a threshold. Sits as a standalone datapath block driven by a control FSM or a bench.

---
 rtl/voter_pkg.sv | 10 +
 rtl/voter_popcount.sv | 14 +
 rtl/voter_plus_ext.sv | 96 +++++++++
 tb/tb_voter_plus_ext.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/voter_pkg.sv
// voter_pkg: shared FSM encoding, default weights and increment width helper for voter_plus_ext
package voter_pkg;
  typedef enum logic [1:0] {S_IDLE, S_OPEN, S_CLOSED} state_e;
  localparam int W_NP_DEF = 1;
  localparam int W_VIP_DEF = 4;
  localparam int W_VVIP_DEF = 16;
  function automatic int inc_width(input int np_n, w_np, vip_n, w_vip, vvip_n, w_vvip);
    return $clog2(np_n * w_np + vip_n * w_vip + vvip_n * w_vvip + 1);
  endfunction
endpackage

// File: rtl/voter_popcount.sv
// voter_popcount: combinational population count of a vote vector
module voter_popcount #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]               bits_i,
  output logic [$clog2(WIDTH+1)-1:0]     count_o
);
  localparam int CW = $clog2(WIDTH + 1);
  // sum the set bits
  always_comb begin
    count_o = '0;
    for (int i = 0; i < WIDTH; i++) count_o = count_o + CW'(bits_i[i]);
  end
endmodule

// File: rtl/voter_plus_ext.sv
// voter_plus_ext: session-based weighted voting tally; VOTER_SAT_EN selects saturating (else wrapping) tally
module voter_plus_ext
  import voter_pkg::*;
#(
  parameter int NP_N    = 32,
  parameter int VIP_N   = 8,
  parameter int VVIP_N  = 1,
  parameter int W_NP    = W_NP_DEF,
  parameter int W_VIP   = W_VIP_DEF,
  parameter int W_VVIP  = W_VVIP_DEF,
  parameter int CNT_W   = 8,
  parameter int PASS_TH = 40
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              close,
  input  logic [NP_N-1:0]   np,
  input  logic [VIP_N-1:0]  vip,
  input  logic [VVIP_N-1:0] vvip,
  output logic [CNT_W-1:0]  result,
  output logic              busy,
  output logic              done,
  output logic              pass
);
  localparam int SUM_W = inc_width(NP_N, W_NP, VIP_N, W_VIP, VVIP_N, W_VVIP) + CNT_W;
  localparam logic [CNT_W-1:0] TH = CNT_W'(PASS_TH);
  state_e state_q;
  logic [NP_N-1:0] voted_np_q;
  logic [VIP_N-1:0] voted_vip_q;
  logic [VVIP_N-1:0] voted_vvip_q;
  logic [CNT_W-1:0] result_q, result_d;
  logic busy_q, done_q, pass_q;
  logic [$clog2(NP_N+1)-1:0] cnt_np;
  logic [$clog2(VIP_N+1)-1:0] cnt_vip;
  logic [$clog2(VVIP_N+1)-1:0] cnt_vvip;
  logic [SUM_W-1:0] sum;
  voter_popcount #(.WIDTH(NP_N)) u_pc_np (.bits_i(np & ~voted_np_q), .count_o(cnt_np));
  voter_popcount #(.WIDTH(VIP_N)) u_pc_vip (.bits_i(vip & ~voted_vip_q), .count_o(cnt_vip));
  voter_popcount #(.WIDTH(VVIP_N)) u_pc_vvip (.bits_i(vvip & ~voted_vvip_q), .count_o(cnt_vvip));
  // next tally from first-time votes only, widened so the add never loses carries
  always_comb begin
    sum = SUM_W'(result_q) + SUM_W'(cnt_np) * SUM_W'(W_NP) + SUM_W'(cnt_vip) * SUM_W'(W_VIP)
        + SUM_W'(cnt_vvip) * SUM_W'(W_VVIP);
`ifdef VOTER_SAT_EN
    result_d = |sum[SUM_W-1:CNT_W] ? '1 : sum[CNT_W-1:0];
`else
    result_d = sum[CNT_W-1:0];
`endif
  end
  // session FSM with registered tally, masks and status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      result_q <= '0;
      voted_np_q <= '0;
      voted_vip_q <= '0;
      voted_vvip_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_OPEN: begin
          result_q <= result_d;
          voted_np_q <= voted_np_q | np;
          voted_vip_q <= voted_vip_q | vip;
          voted_vvip_q <= voted_vvip_q | vvip;
          if (close) begin
            state_q <= S_CLOSED;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            pass_q <= result_d >= TH;
          end
        end
        S_IDLE, S_CLOSED: begin
          if (start) begin
            state_q <= S_OPEN;
            result_q <= '0;
            voted_np_q <= '0;
            voted_vip_q <= '0;
            voted_vvip_q <= '0;
            busy_q <= 1'b1;
            pass_q <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
  assign result = result_q;
  assign busy = busy_q;
  assign done = done_q;
  assign pass = pass_q;
endmodule

// File: tb/tb_voter_plus_ext.sv
// tb_voter_plus_ext: directed self-checking bench for voter_plus_ext (default and CNT_W=6 instances)
module tb_voter_plus_ext;
  logic clk = 1'b0;
  logic reset, start, close, start6;
  logic [31:0] np, np6;
  logic [7:0] vip, vip6;
  logic [0:0] vvip, vvip6;
  logic [7:0] result;
  logic [5:0] result6;
  logic busy, done, pass, busy6, done6, pass6;
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  voter_plus_ext u_dut (
    .clk(clk), .reset(reset), .start(start), .close(close), .np(np), .vip(vip), .vvip(vvip),
    .result(result), .busy(busy), .done(done), .pass(pass)
  );
  voter_plus_ext #(.CNT_W(6)) u_w6 (
    .clk(clk), .reset(reset), .start(start6), .close(1'b0), .np(np6), .vip(vip6), .vvip(vvip6),
    .result(result6), .busy(busy6), .done(done6), .pass(pass6)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    reset = 1'b1; start = 1'b0; close = 1'b0; np = '0; vip = '0; vvip = '0;
    start6 = 1'b0; np6 = '0; vip6 = '0; vvip6 = '0;
    step();
    step();
    chk("rst_result", 32'(result), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_pass", 32'(pass), 0);
    reset = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    chk("open_busy", 32'(busy), 1);
    chk("open_result", 32'(result), 0);
    np = 32'h86F7; vip = 8'h0F;
    step();
    chk("first_tally", 32'(result), 26);
    np = 32'hFFFF; vip = 8'hFF; vvip = 1'b1;
    step();
    chk("second_tally", 32'(result), 64);
    for (int i = 0; i < 5; i++) step();
    chk("held_once", 32'(result), 64);
    close = 1'b1;
    step();
    close = 1'b0;
    chk("close_busy", 32'(busy), 0);
    chk("close_done", 32'(done), 1);
    chk("close_pass", 32'(pass), 1);
    np = 32'hFFFF_FFFF;
    step();
    chk("done_pulse", 32'(done), 0);
    chk("closed_hold", 32'(result), 64);
    chk("closed_pass", 32'(pass), 1);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart_result", 32'(result), 0);
    chk("restart_busy", 32'(busy), 1);
    chk("restart_pass", 32'(pass), 0);
    np = 32'h1; vip = '0; vvip = '0;
    step();
    chk("masks_cleared", 32'(result), 1);
    np = 32'h0;
    step();
    np = 32'h1;
    step();
    chk("reassert_once", 32'(result), 1);
    np = 32'h3; close = 1'b1;
    step();
    close = 1'b0; np = '0;
    chk("close_cycle_vote", 32'(result), 2);
    chk("low_pass", 32'(pass), 0);
    chk("low_done", 32'(done), 1);
    start = 1'b1;
    step();
    start = 1'b0; np = 32'hFF; vip = 8'hFF;
    step();
    np = '0; vip = '0;
    chk("th_tally", 32'(result), 40);
    close = 1'b1;
    step();
    close = 1'b0;
    chk("th_inclusive", 32'(pass), 1);
    start = 1'b1;
    step();
    start = 1'b0; np = 32'h7;
    step();
    np = '0; start = 1'b1; close = 1'b1;
    step();
    start = 1'b0; close = 1'b0;
    chk("sc_done", 32'(done), 1);
    chk("sc_busy", 32'(busy), 0);
    chk("sc_result", 32'(result), 3);
    reset = 1'b1;
    step();
    reset = 1'b0; np = 32'hFFFF_FFFF; vip = 8'hFF; vvip = 1'b1;
    step();
    chk("idle_ignored", 32'(result), 0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("idle_start_votes", 32'(result), 0);
    np = 32'hF; vip = '0; vvip = '0;
    step();
    chk("mid_tally", 32'(result), 4);
    reset = 1'b1; np = 32'hFF;
    step();
    reset = 1'b0;
    chk("mrst_result", 32'(result), 0);
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_done", 32'(done), 0);
    chk("mrst_pass", 32'(pass), 0);
    step();
    chk("mrst_ignored", 32'(result), 0);
    np = '0;
    start6 = 1'b1;
    step();
    start6 = 1'b0; np6 = 32'hFFFF_FFFF; vip6 = 8'hFF; vvip6 = 1'b1;
    step();
`ifdef VOTER_SAT_EN
    chk("w6_overflow", 32'(result6), 63);
`else
    chk("w6_overflow", 32'(result6), 16);
`endif
    step();
`ifdef VOTER_SAT_EN
    chk("w6_hold", 32'(result6), 63);
`else
    chk("w6_hold", 32'(result6), 16);
`endif
    chk("w6_busy", 32'(busy6), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
